des_link_sched: RTL

- Frame scheduler and arbiter for the shared 8-cycle DES link. The link serialises a 64-bit outbound word as four 16-bit phases and assembles a 52-bit inbound word from four 13-bit phases.
- Outbound: picks one of NREQ requesters round-robin per frame, formats its payload into the 64-bit word and holds it stable for the whole frame.
- Inbound: decodes each completed 52-bit word into a one-entry receive buffer with valid/ready handshake and a drop counter.
- Sits between client logic and the DES link, on the same in_clk.

---
 rtl/des_link_sched.sv | 95 +++++++++
 1 files changed

// File: rtl/des_link_sched.sv
// DES link frame scheduler: round-robin outbound grant at fc==7 (word registered for the next frame),
// one-entry inbound buffer loaded at fc==4; a full buffer that is not draining drops the frame and counts it.
module des_link_sched #(
  parameter int NREQ   = 4,
  parameter int DROP_W = 8
) (
  input  logic                in_clk,
  input  logic                rst,
  input  logic                link_en,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*60-1:0]  req_data,
  output logic [63:0]         des_din,
  input  logic [51:0]         des_dout,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [2:0]          rx_dest,
  output logic [47:0]         rx_data,
  output logic [DROP_W-1:0]   rx_drop_cnt
);

  logic [2:0]        fc;
  logic [2:0]        ptr;
  logic [2*NREQ-1:0] rot_c;
  logic              any_c;
  logic [2:0]        gidx_c;
  logic [59:0]       payload_c;
  logic [NREQ-1:0]   sel_c;
  logic              grant_slot;
  logic              rx_take;

  // Rotate requests so bit 0 is the current round-robin head, then take the first set bit.
  always_comb begin
    rot_c     = {req_valid, req_valid} >> ptr;
    any_c     = 1'b0;
    gidx_c    = 3'd0;
    payload_c = '0;
    sel_c     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_c && rot_c[k]) begin
        any_c  = 1'b1;
        gidx_c = 3'((int'(ptr) + k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_c == 3'(i)) begin
        payload_c = req_data[60*i +: 60];
        sel_c[i]  = any_c;
      end
    end
  end

  assign grant_slot = !rst && (fc == 3'd7) && link_en;
  assign req_ready  = grant_slot ? sel_c : '0;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      fc      <= 3'b111;
      ptr     <= 3'd0;
      des_din <= 64'h0;
    end else begin
      fc <= fc + 3'd1;
      if (fc == 3'd7) begin
        if (grant_slot && any_c) begin
          des_din <= {1'b1, gidx_c, payload_c};
          ptr     <= 3'((int'(gidx_c) + 1) % NREQ);
        end else begin
          des_din <= 64'h0;
        end
      end
    end
  end

  assign rx_take = (fc == 3'd4) && link_en && des_dout[51];

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_dest     <= 3'd0;
      rx_data     <= 48'h0;
      rx_drop_cnt <= '0;
    end else if (rx_take) begin
      if (!rx_valid || rx_ready) begin
        rx_valid <= 1'b1;
        rx_dest  <= des_dout[50:48];
        rx_data  <= des_dout[47:0];
      end else if (rx_drop_cnt != '1) begin
        rx_drop_cnt <= rx_drop_cnt + DROP_W'(1);
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
